// File: rtl/drm_activator_event_arbiter.sv
// rtl/drm_activator_event_arbiter.sv - multi-channel metering event arbiter with IP-core POR
// Optional sticky overflow flags: define DRM_ACT_EVT_OVERFLOW_EN.
module drm_activator_event_arbiter #(
   parameter int NUM_EVT      = 4,
   parameter int CNT_W        = 8,
   parameter int POR_DURATION = 16,
   parameter int MIN_GAP      = 0,
   parameter int CODE_W       = 128,
   localparam int CH_W        = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
   input  logic                drm_aclk,
   input  logic                drm_arstn,
   input  logic [NUM_EVT-1:0]  metering_event,
   input  logic [CODE_W-1:0]   activation_code,
   input  logic                activation_code_ready,
   input  logic                overflow_clr,
   output logic                ip_core_arstn,
   output logic                drm_event,
   output logic [CH_W-1:0]     drm_event_ch,
   output logic [NUM_EVT-1:0]  ch_enable,
   output logic                pending_any,
   output logic [NUM_EVT-1:0]  overflow
);

   localparam logic [1:0]    ST_IDLE   = 2'd0;
   localparam logic [1:0]    ST_GRANT  = 2'd1;
   localparam logic [1:0]    ST_GAP    = 2'd2;
   localparam logic [7:0]    GAP_LAST  = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;
   localparam logic [CH_W:0] NUM_EVT_W = (CH_W + 1)'(NUM_EVT);

   logic [POR_DURATION-1:0] por_sr;
   logic [NUM_EVT-1:0]      cnt_nz;
   logic [NUM_EVT-1:0]      sat;
   logic [NUM_EVT-1:0]      rot_nz;
   logic [1:0]              state;
   logic [7:0]              gap_cnt;
   logic [CH_W-1:0]         rr_ptr;
   logic [CH_W-1:0]         grant_off;
   logic [CH_W-1:0]         grant_ch;
   logic [CH_W-1:0]         ptr_next;
   logic [CH_W:0]           grant_sum;
   logic [CH_W:0]           ptr_sum;
   logic                    grant_found;
   logic                    do_grant;

   always_ff @(posedge drm_aclk or negedge drm_arstn) begin
      if (!drm_arstn) por_sr <= '0;
      else            por_sr <= {por_sr[POR_DURATION-2:0], 1'b1};
   end
   assign ip_core_arstn = por_sr[POR_DURATION-1];

   always_ff @(posedge drm_aclk or negedge drm_arstn) begin
      if (!drm_arstn)                 ch_enable <= '0;
      else if (activation_code_ready) ch_enable <= activation_code[NUM_EVT-1:0];
   end

   // Counting ignores the POR window; only granting waits for ip_core_arstn.
   for (genvar i = 0; i < NUM_EVT; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             inc;
      logic             dec;
      assign inc = metering_event[i] & ch_enable[i];
      assign dec = do_grant & (grant_ch == CH_W'(i));
      always_ff @(posedge drm_aclk or negedge drm_arstn) begin
         if (!drm_arstn)                   cnt <= '0;
         else if (inc && !dec && !(&cnt))  cnt <= cnt + 1'b1;
         else if (dec && !inc)             cnt <= cnt - 1'b1;
      end
      assign cnt_nz[i] = |cnt;
      assign sat[i]    = inc & ~dec & (&cnt);
   end

   // Rotate so bit 0 is the pointer channel, then take the lowest set offset.
   assign rot_nz = NUM_EVT'({cnt_nz, cnt_nz} >> rr_ptr);

   always_comb begin
      grant_found = 1'b0;
      grant_off   = '0;
      for (int k = NUM_EVT - 1; k >= 0; k--) begin
         if (rot_nz[k]) begin
            grant_found = 1'b1;
            grant_off   = CH_W'(k);
         end
      end
   end

   assign grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
   assign grant_ch  = (grant_sum >= NUM_EVT_W) ? CH_W'(grant_sum - NUM_EVT_W) : grant_sum[CH_W-1:0];
   assign ptr_sum   = {1'b0, grant_ch} + 1'b1;
   assign ptr_next  = (ptr_sum == NUM_EVT_W) ? '0 : ptr_sum[CH_W-1:0];

   // IDLE grants on the same edge it leaves, giving two-cycle event latency.
   assign do_grant = ip_core_arstn & grant_found & (state != ST_GAP);

   always_ff @(posedge drm_aclk or negedge drm_arstn) begin
      if (!drm_arstn) begin
         state        <= ST_IDLE;
         gap_cnt      <= '0;
         rr_ptr       <= '0;
         drm_event    <= 1'b0;
         drm_event_ch <= '0;
         pending_any  <= 1'b0;
      end else begin
         drm_event   <= do_grant;
         pending_any <= |cnt_nz;
         if (do_grant) begin
            drm_event_ch <= grant_ch;
            rr_ptr       <= ptr_next;
         end
         case (state)
            ST_IDLE, ST_GRANT: begin
               gap_cnt <= '0;
               if (do_grant) state <= (MIN_GAP > 0) ? ST_GAP : ST_GRANT;
               else          state <= ST_IDLE;
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) state <= grant_found ? ST_GRANT : ST_IDLE;
               else                     gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef DRM_ACT_EVT_OVERFLOW_EN
   always_ff @(posedge drm_aclk or negedge drm_arstn) begin
      if (!drm_arstn) overflow <= '0;
      else            overflow <= (overflow & ~{NUM_EVT{overflow_clr}}) | sat;
   end
   logic unused_code;
   assign unused_code = ^activation_code;
`else
   assign overflow = '0;
   logic unused_inputs;
   assign unused_inputs = ^{activation_code, overflow_clr, sat};
`endif

endmodule
